// File: rtl/swivm_mem_arbiter_pkg.sv
// swivm_pkg: shared definitions for the SwiVM memory arbiter.
//   REQ_F/REQ_D/REQ_X : requester indices (bit positions in req/gnt vectors)
//   state_t           : arbiter access FSM states
//   req_next()        : next requester index in F->D->X rotation order
package swivm_pkg;

  localparam logic [1:0] REQ_F = 2'd0;
  localparam logic [1:0] REQ_D = 2'd1;
  localparam logic [1:0] REQ_X = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  function automatic logic [1:0] req_next(input logic [1:0] idx);
    return (idx == REQ_X) ? REQ_F : idx + 2'd1;
  endfunction

endpackage

// File: rtl/swivm_mem_arbiter_pick.sv
// swivm_arb_pick: combinational 3-way requester picker.
//   req_i  [2:0] request vector indexed by REQ_F/REQ_D/REQ_X
//   prio_i [1:0] requester holding highest priority (only with SWIVM_ARB_RR_EN)
//   gnt_o  [2:0] one-hot winner, all zero when no request
// Macro SWIVM_ARB_RR_EN: rotating priority starting at prio_i (F->D->X order).
// Without it: fixed priority D > X > F.
module swivm_arb_pick
  import swivm_pkg::*;
(
  input  logic [2:0] req_i,
`ifdef SWIVM_ARB_RR_EN
  input  logic [1:0] prio_i,
`endif
  output logic [2:0] gnt_o
);

`ifdef SWIVM_ARB_RR_EN
  logic [1:0] c0, c1, c2;
`endif

  always_comb begin
    gnt_o = '0;
`ifdef SWIVM_ARB_RR_EN
    c0 = prio_i;
    c1 = req_next(c0);
    c2 = req_next(c1);
    if (req_i[c0])      gnt_o[c0] = 1'b1;
    else if (req_i[c1]) gnt_o[c1] = 1'b1;
    else if (req_i[c2]) gnt_o[c2] = 1'b1;
`else
    if (req_i[REQ_D])      gnt_o[REQ_D] = 1'b1;
    else if (req_i[REQ_X]) gnt_o[REQ_X] = 1'b1;
    else if (req_i[REQ_F]) gnt_o[REQ_F] = 1'b1;
`endif
  end

endmodule

// File: rtl/swivm_mem_arbiter.sv
// swivm_mem_arbiter: shares one single-port synchronous RAM between the
// SwiVM fetch (F), data (D) and loader/debug (X) requesters. One access at
// a time, IDLE -> ISSUE -> RESP, so one access every 3 cycles.
//   clk, reset                 clock, synchronous active-high reset
//   f_req/f_addr               fetch read request
//   d_req/d_we/d_addr/d_wdata  data read/write request
//   x_req/x_we/x_addr/x_wdata  loader read/write request
//   *_gnt                      one-cycle grant pulse (ISSUE cycle)
//   *_rvalid, rdata            one-cycle completion pulse, read data (0 for writes)
//   mem_en/we/addr/wdata       RAM strobe and request, registered
//   mem_rdata                  RAM read data, valid one cycle after mem_en
// Macro SWIVM_ARB_RR_EN: round-robin F->D->X instead of fixed D > X > F.
module swivm_mem_arbiter
  import swivm_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              x_req,
  input  logic              x_we,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_wdata,
  output logic              f_gnt,
  output logic              d_gnt,
  output logic              x_gnt,
  output logic              f_rvalid,
  output logic              d_rvalid,
  output logic              x_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [2:0]        rvalid_q, rvalid_d;
  logic [2:0]        req, pick;
`ifdef SWIVM_ARB_RR_EN
  logic [1:0]        prio_q, prio_d;
`endif

  assign req = {x_req, d_req, f_req};

  swivm_arb_pick u_pick (
    .req_i  (req),
`ifdef SWIVM_ARB_RR_EN
    .prio_i (prio_q),
`endif
    .gnt_o  (pick)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    we_d        = we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    gnt_d       = '0;
    rvalid_d    = '0;
`ifdef SWIVM_ARB_RR_EN
    prio_d      = prio_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          if (pick[REQ_D]) begin
            we_d        = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
`ifdef SWIVM_ARB_RR_EN
            prio_d      = req_next(REQ_D);
`endif
          end else if (pick[REQ_X]) begin
            we_d        = x_we;
            mem_addr_d  = x_addr;
            mem_wdata_d = x_wdata;
`ifdef SWIVM_ARB_RR_EN
            prio_d      = req_next(REQ_X);
`endif
          end else begin
            we_d        = 1'b0;
            mem_addr_d  = f_addr;
            mem_wdata_d = '0;
`ifdef SWIVM_ARB_RR_EN
            prio_d      = req_next(REQ_F);
`endif
          end
          sel_d    = pick;
          // Grant and RAM strobe are registered here so they appear in the ISSUE cycle.
          gnt_d    = pick;
          mem_en_d = 1'b1;
          mem_we_d = we_d;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rvalid_d = sel_q;
        state_d  = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
`ifdef SWIVM_ARB_RR_EN
      prio_q      <= REQ_F;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
`ifdef SWIVM_ARB_RR_EN
      prio_q      <= prio_d;
`endif
    end
  end

  assign f_gnt     = gnt_q[REQ_F];
  assign d_gnt     = gnt_q[REQ_D];
  assign x_gnt     = gnt_q[REQ_X];
  assign f_rvalid  = rvalid_q[REQ_F];
  assign d_rvalid  = rvalid_q[REQ_D];
  assign x_rvalid  = rvalid_q[REQ_X];
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  // RAM data arrives in the RESP cycle itself, so it is passed through, not re-registered.
  assign rdata     = (|rvalid_q && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_swivm_mem_arbiter.sv
module tb_swivm_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  rq;
  logic [15:0] r_addr [3];
  logic        r_we [3];
  logic [31:0] r_wdata [3];
  logic        f_gnt, d_gnt, x_gnt, f_rvalid, d_rvalid, x_rvalid;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;

  always #5 clk = ~clk;

  swivm_mem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .f_req(rq[0]), .f_addr(r_addr[0]),
    .d_req(rq[1]), .d_we(r_we[1]), .d_addr(r_addr[1]), .d_wdata(r_wdata[1]),
    .x_req(rq[2]), .x_we(r_we[2]), .x_addr(r_addr[2]), .x_wdata(r_wdata[2]),
    .f_gnt(f_gnt), .d_gnt(d_gnt), .x_gnt(x_gnt),
    .f_rvalid(f_rvalid), .d_rvalid(d_rvalid), .x_rvalid(x_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] pat(input logic [15:0] a);
    return 32'hA5A5_0000 ^ {16'h0, a};
  endfunction

  // RAM model: synchronous, write-first (write returns the written word on mem_rdata).
  logic [31:0] ram   [0:65535];
  bit          ram_v [0:65535];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]   <= mem_wdata;
        ram_v[mem_addr] <= 1'b1;
        mem_rdata       <= mem_wdata;
      end else begin
        mem_rdata <= ram_v[mem_addr] ? ram[mem_addr] : pat(mem_addr);
      end
    end
  end

  // Reference memory and scoreboard.
  logic [31:0] ref_m [0:65535];
  bit          ref_v [0:65535];
  typedef struct { int id; logic [31:0] d; } rv_t;
  int  eg[$];
  rv_t er[$];
  int  mptr;
  int  n_chk = 0, n_bad = 0, cyc = 0, gcyc = 0, rv_seen = 0;
  logic prev_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int mpick(input logic [2:0] m, input int p);
`ifdef SWIVM_ARB_RR_EN
    for (int k = 0; k < 3; k++) begin
      int c;
      c = (p + k) % 3;
      if (m[c]) return c;
    end
    return 0;
`else
    if (m[1]) return 1;
    if (m[2]) return 2;
    return 0;
`endif
  endfunction

  task automatic monitor();
    logic [2:0] g, v;
    int e;
    rv_t r;
    g = {x_gnt, d_gnt, f_gnt};
    v = {x_rvalid, d_rvalid, f_rvalid};
    if (mem_en) check("mem_en_b2b", {31'b0, prev_en}, 32'd0);
    prev_en = mem_en;
    if (|g) begin
      check("gnt_onehot", $countones(g), 32'd1);
      gcyc = cyc;
      if (eg.size() == 0) check("gnt_unexpected", {29'b0, g}, 32'd0);
      else begin
        e = eg.pop_front();
        check("gnt_who", {29'b0, g}, 32'd1 << e);
      end
    end
    if (|v) begin
      rv_seen++;
      check("rv_onehot", $countones(v), 32'd1);
      check("rv_latency", cyc - gcyc, 32'd1);
      if (er.size() == 0) check("rv_unexpected", {29'b0, v}, 32'd0);
      else begin
        r = er.pop_front();
        check("rv_who", {29'b0, v}, 32'd1 << r.id);
        check("rdata", rdata, r.d);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"}, {24'b0, f_gnt, d_gnt, x_gnt, f_rvalid, d_rvalid, x_rvalid, mem_en, mem_we}, 32'd0);
    check({tag, "_addr"}, {16'b0, mem_addr}, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
  endtask

  task automatic reset_dut();
    rq = '0;
    reset = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    mptr = 0;
    tick();
  endtask

  // Raise the requests in mask; each requester drops in its grant cycle.
  // With cont set, granted requesters re-raise in the RESP cycle (continuous traffic).
  task automatic run(input logic [2:0] mask, input int ngr, input bit cont);
    logic [2:0] m, g, rearm;
    int w, got, last, start;
    m = mask;
    for (int k = 0; k < ngr; k++) begin
      w = mpick(m, mptr);
      mptr = (w + 1) % 3;
      eg.push_back(w);
      if (r_we[w]) begin
        ref_m[r_addr[w]] = r_wdata[w];
        ref_v[r_addr[w]] = 1'b1;
        er.push_back('{id: w, d: 32'h0});
      end else begin
        er.push_back('{id: w, d: ref_v[r_addr[w]] ? ref_m[r_addr[w]] : pat(r_addr[w])});
      end
      if (!cont) m[w] = 1'b0;
    end
    got = 0; last = 0; rearm = '0;
    rq = mask;
    start = cyc;
    for (int t = 0; t < ngr * 3 + 10 && got < ngr; t++) begin
      tick();
      rq = rq | rearm;
      rearm = '0;
      g = {x_gnt, d_gnt, f_gnt};
      if (|g) begin
        got++;
        if (got == 1) check("first_gnt_latency", cyc - start, 32'd1);
        else          check("gnt_period", cyc - last, 32'd3);
        last = cyc;
        rq = rq & ~g;
        if (cont && got < ngr) rearm = g;
      end
    end
    rq = '0;
    if (got < ngr) check("grant_timeout", got, ngr);
    repeat (4) tick();
    check("sb_drained", eg.size() + er.size(), 32'd0);
    eg.delete();
    er.delete();
  endtask

  task automatic setreq(input int id, input logic [15:0] a, input logic we, input logic [31:0] wd);
    r_addr[id] = a;
    r_we[id] = (id == 0) ? 1'b0 : we;
    r_wdata[id] = wd;
  endtask

  initial begin
    int rv0;
    logic [2:0] rm;
    rq = '0;
    reset = 1'b1;
    mptr = 0;
    for (int i = 0; i < 3; i++) setreq(i, 16'h0, 1'b0, 32'h0);
    for (int i = 0; i < 65536; i++) ref_v[i] = 1'b0;
    reset_dut();

    // Reset in the middle of an F access: grant seen, completion must never appear.
    setreq(0, 16'h0040, 1'b0, 32'h0);
    eg.push_back(0);
    rq = 3'b001;
    tick();
    check("abort_gnt", {31'b0, f_gnt}, 32'd1);
    rq = '0;
    rv0 = rv_seen;
    reset_dut();
    repeat (4) tick();
    check("abort_no_rvalid", rv_seen - rv0, 32'd0);
    eg.delete();

    // Preload via loader write, then fetch read.
    setreq(2, 16'h0010, 1'b1, 32'hDEAD_BEEF);
    run(3'b100, 1, 1'b0);
    setreq(0, 16'h0010, 1'b0, 32'h0);
    run(3'b001, 1, 1'b0);

    // Data write (rdata 0), then fetch read-back.
    setreq(1, 16'h0020, 1'b1, 32'h1234_5678);
    run(3'b010, 1, 1'b0);
    setreq(0, 16'h0020, 1'b0, 32'h0);
    run(3'b001, 1, 1'b0);

    // All three at once from reset.
    reset_dut();
    setreq(0, 16'h0030, 1'b0, 32'h0);
    setreq(1, 16'h0020, 1'b0, 32'h0);
    setreq(2, 16'h0010, 1'b0, 32'h0);
    run(3'b111, 3, 1'b0);

    // Mixed writes and read on the same word.
    setreq(0, 16'h0050, 1'b0, 32'h0);
    setreq(1, 16'h0050, 1'b1, 32'hCAFE_0001);
    setreq(2, 16'h0050, 1'b1, 32'hCAFE_0002);
    run(3'b111, 3, 1'b0);

    // Continuous D + F traffic from reset.
    reset_dut();
    setreq(0, 16'h0010, 1'b0, 32'h0);
    setreq(1, 16'h0020, 1'b0, 32'h0);
    run(3'b011, 6, 1'b1);

    // Random batches.
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 3; i++)
        setreq(i, 16'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom);
      rm = 3'($urandom_range(1, 7));
      run(rm, $countones(rm), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
